mem_slot_arb: RTL and testbench
===============================

# mem_slot_arb

Memory-slot arbiter for the GSTMCU DRAM path. It consumes the `cycsel` memory-cycle strobe from the clock generator and assigns each slot to exactly one owner:
- video
- sound DMA
- refresh
- CPU
- disk/ACSI DMA

It also runs the DMA bus-mastership handshake and generates CPU DTACK.

## Interface
Parameters:
- `REFRESH_DIV`, 64: slots between refresh requests (≥2).
- `DTACK_DLY`, 2: clocks from CPU slot grant to `dtack` assertion (1..7).

Ports:
- `clk`  in  1  master clock; all state on rising edge.
- `resb`  in  1  asynchronous active-low reset.
- `cycsel`  in  1  slot strobe from clockgen; each rising edge starts a slot.
- `vid_req`  in  1  shifter wants a fetch this even slot.
- `snd_req`  in  1  sound DMA wants a fetch.
- `cpu_as`  in  1  CPU address strobe (active high, already synchronised).
- `dma_req`  in  1  disk DMA bus request, level.
- `vid_gnt`, `snd_gnt`, `ref_gnt`, `cpu_gnt`, `dma_gnt`  out  1 each  slot owner, one-hot or all zero.
- `slot_odd`  out  1  parity of current slot.
- `bus_dma`  out  1  DMA holds bus mastership.
- `dtack`  out  1  CPU data acknowledge.
- `ref_ovf`  out  1  one-clock pulse: refresh request lost.

## Operation
Slot detection:
- `cyc_d` registers `cycsel`.
- `start = cycsel & ~cyc_d`.
- Every `start` toggles `slot_odd` and re-evaluates all grants.
- Grants are held constant for the whole slot, up to the next `start`.

Even slot (new `slot_odd`=0), priority high→low:
1. `vid_gnt` if `vid_req`.
2. `snd_gnt` if `snd_req`.
3. `ref_gnt` if refresh pending; serving it clears pending.
4. Otherwise all zero, unless `CPU_EVENSHARE_EN` applies (see Configuration).

Odd slot:
- Bus state CPU: `cpu_gnt` = `cpu_as`.
- Bus state DMA: `dma_gnt` = `dma_req`.
- Otherwise no grant.

Refresh:
- A slot counter counts 0..REFRESH_DIV-1 on every `start` and wraps.
- On wrap, pending is set.
- If pending is already set at wrap and not served in that same slot: pending stays 1 and `ref_ovf` pulses for one clock.

Bus state machine:
- CPU → WAIT: at `start` with `dma_req`=1.
- WAIT → DMA: at the first `start` where `cpu_as`=0 and the previous slot had no `cpu_gnt`.
- DMA → CPU: at `start` with `dma_req`=0.
- WAIT → CPU: if `dma_req` drops before the handoff.
- `bus_dma` = (state == DMA).

DTACK:
- A 3-bit counter loads 0 when `cpu_gnt` becomes 1 and counts up while `cpu_gnt` & `cpu_as`.
- `dtack` = 1 when the counter ≥ DTACK_DLY and `cpu_gnt` & `cpu_as`.
- `dtack` drops in the same clock `cpu_as` falls (combinational gate) and is 0 outside CPU slots.

## Timing
- Reset values:
  - all grants 0, `slot_odd` 0, `bus_dma` 0, `dtack` 0, `ref_ovf` 0.
  - refresh counter 0, pending 0, bus state CPU, `cyc_d` 0.
- Latency: grants, `slot_odd` and `bus_dma` change on the clock edge where `start`=1, i.e. one clock after the `cycsel` rise is visible.
- Requests are sampled only at `start`:
  - raising `vid_req`, `snd_req` or `cpu_as` mid-slot takes effect next eligible slot.
  - dropping a request mid-slot does not release the grant until slot end (`dtack` still gates on `cpu_as`).
- `cycsel` held high across many clocks: one `start` only.
- A `cycsel` pulse shorter than one clock but sampled high still counts.
- Simultaneous wrap and refresh service in the same even slot: refresh is served and pending remains set (new request), no `ref_ovf`.
- `resb` low mid-slot: all outputs go to reset values immediately, without waiting for `clk`. After release, the first `start` produces slot_odd=1.

## Configuration
- `CPU_EVENSHARE_EN` defined: in bus state CPU, an even slot with no video/sound/refresh owner grants `cpu_gnt` if `cpu_as`, and `dtack` runs as in odd slots.
- `CPU_EVENSHARE_EN` undefined: free even slots stay idle and the CPU is served only on odd slots.

## Test plan
- Reset, then 8 `cycsel` pulses with `cpu_as`=1, other requests 0 → `cpu_gnt` on slots 1,3,5,7 only (every even slot too with `CPU_EVENSHARE_EN`); `dtack` rises DTACK_DLY clocks after each grant.
- `vid_req`=`snd_req`=1 always → every even slot `vid_gnt`, never `snd_gnt`. With REFRESH_DIV=4, `ref_ovf` pulses at the second wrap.
- `vid_req`=0, `snd_req`=0, REFRESH_DIV=4 → `ref_gnt` in the first even slot after each wrap, `ref_ovf` never.
- `dma_req` raised while `cpu_as`=1 for 3 odd slots → `bus_dma` rises at the first `start` after `cpu_as` falls with no CPU grant in the prior slot. `dma_gnt` is on odd slots; dropping `dma_req` returns to CPU at the next `start`.
- `resb` pulsed low mid-CPU-slot with `dtack`=1 → `dtack` and `cpu_gnt` 0 asynchronously; the next `start` gives `slot_odd`=1 and a fresh DTACK_DLY count.

Source files
------------

// File: rtl/mem_slot_arb.sv
// DRAM slot arbiter: assigns each cycsel slot to video, sound, refresh, CPU or disk DMA,
// runs the DMA bus handoff and generates CPU DTACK. Optional macro: CPU_EVENSHARE_EN.
module mem_slot_arb #(
    parameter int REFRESH_DIV = 64,
    parameter int DTACK_DLY   = 2
) (
    input  logic clk,
    input  logic resb,
    input  logic cycsel,
    input  logic vid_req,
    input  logic snd_req,
    input  logic cpu_as,
    input  logic dma_req,
    output logic vid_gnt,
    output logic snd_gnt,
    output logic ref_gnt,
    output logic cpu_gnt,
    output logic dma_gnt,
    output logic slot_odd,
    output logic bus_dma,
    output logic dtack,
    output logic ref_ovf
);

    localparam int RCW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        BUS_CPU  = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_DMA  = 2'd2
    } bus_t;

    bus_t           bus_state;
    logic           cyc_d;
    logic           start;
    logic [RCW-1:0] ref_cnt;
    logic           ref_pend;
    logic           wrap;
    logic [2:0]     dtk_cnt;
    logic           g_vid, g_snd, g_ref, g_cpu, g_dma;

    assign start = cycsel & ~cyc_d;
    assign wrap  = (ref_cnt == RCW'(REFRESH_DIV - 1));

    // Owner of the slot that the next start opens; slot_odd=1 now means the next slot is even.
    always_comb begin
        g_vid = 1'b0;
        g_snd = 1'b0;
        g_ref = 1'b0;
        g_cpu = 1'b0;
        g_dma = 1'b0;
        if (slot_odd) begin
            if (vid_req)
                g_vid = 1'b1;
            else if (snd_req)
                g_snd = 1'b1;
            else if (ref_pend)
                g_ref = 1'b1;
`ifdef CPU_EVENSHARE_EN
            else if (bus_state == BUS_CPU)
                g_cpu = cpu_as;
`endif
        end else begin
            case (bus_state)
                BUS_CPU: g_cpu = cpu_as;
                BUS_DMA: g_dma = dma_req;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            cyc_d     <= 1'b0;
            slot_odd  <= 1'b0;
            vid_gnt   <= 1'b0;
            snd_gnt   <= 1'b0;
            ref_gnt   <= 1'b0;
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            ref_cnt   <= '0;
            ref_pend  <= 1'b0;
            ref_ovf   <= 1'b0;
            bus_state <= BUS_CPU;
            bus_dma   <= 1'b0;
            dtk_cnt   <= 3'd0;
        end else begin
            cyc_d   <= cycsel;
            ref_ovf <= 1'b0;
            if (start) begin
                slot_odd <= ~slot_odd;
                vid_gnt  <= g_vid;
                snd_gnt  <= g_snd;
                ref_gnt  <= g_ref;
                cpu_gnt  <= g_cpu;
                dma_gnt  <= g_dma;
                ref_cnt  <= wrap ? '0 : ref_cnt + RCW'(1);
                // A wrap in the slot that serves the old request re-arms pending without loss.
                ref_pend <= (ref_pend & ~g_ref) | wrap;
                ref_ovf  <= wrap & ref_pend & ~g_ref;
                case (bus_state)
                    BUS_CPU: begin
                        if (dma_req)
                            bus_state <= BUS_WAIT;
                    end
                    BUS_WAIT: begin
                        if (!dma_req) begin
                            bus_state <= BUS_CPU;
                        end else if (!cpu_as && !cpu_gnt) begin
                            bus_state <= BUS_DMA;
                            bus_dma   <= 1'b1;
                        end
                    end
                    BUS_DMA: begin
                        if (!dma_req) begin
                            bus_state <= BUS_CPU;
                            bus_dma   <= 1'b0;
                        end
                    end
                    default: begin
                        bus_state <= BUS_CPU;
                        bus_dma   <= 1'b0;
                    end
                endcase
            end
            if (start && g_cpu)
                dtk_cnt <= 3'd0;
            else if (cpu_gnt && cpu_as && dtk_cnt != 3'd7)
                dtk_cnt <= dtk_cnt + 3'd1;
        end
    end

    // Gated directly by cpu_as so the acknowledge drops in the clock the strobe falls.
    assign dtack = cpu_gnt & cpu_as & (dtk_cnt >= 3'(DTACK_DLY));

endmodule

// File: tb/tb_mem_slot_arb.sv
// Bench for mem_slot_arb: directed scenarios plus random slots against a slot-level model.
`timescale 1ns/1ps
module tb_mem_slot_arb;

    localparam int DIV = 4;
    localparam int DLY = 2;
    localparam int M_CPU = 0, M_WAIT = 1, M_DMA = 2;

    logic clk = 1'b0;
    logic resb = 1'b0;
    logic cycsel = 1'b0;
    logic vid_req = 1'b0, snd_req = 1'b0, cpu_as = 1'b0, dma_req = 1'b0;
    logic vid_gnt, snd_gnt, ref_gnt, cpu_gnt, dma_gnt;
    logic slot_odd, bus_dma, dtack, ref_ovf;

    int checks = 0;
    int errors = 0;

    mem_slot_arb #(.REFRESH_DIV(DIV), .DTACK_DLY(DLY)) dut (
        .clk(clk), .resb(resb), .cycsel(cycsel),
        .vid_req(vid_req), .snd_req(snd_req), .cpu_as(cpu_as), .dma_req(dma_req),
        .vid_gnt(vid_gnt), .snd_gnt(snd_gnt), .ref_gnt(ref_gnt), .cpu_gnt(cpu_gnt),
        .dma_gnt(dma_gnt), .slot_odd(slot_odd), .bus_dma(bus_dma), .dtack(dtack),
        .ref_ovf(ref_ovf)
    );

    always #5 clk = ~clk;

    // Slot-level reference state
    int         m_n;
    bit         m_pend;
    int         m_mode;
    bit         m_last_cpu;
    logic [4:0] m_g;
    bit         m_ovf;

    // Per-clock vectors {vid,snd,ref,cpu,dma,odd,bus,dtack,ovf}
    logic [8:0] obs_v [16];
    logic [8:0] exp_v [16];
    int         cur_len;

    task automatic model_reset();
        m_n = 0; m_pend = 0; m_mode = M_CPU; m_last_cpu = 0;
    endtask

    task automatic model_start();
        bit odd, wrap, served;
        m_n++;
        odd = (m_n % 2) == 1;
        wrap = (m_n % DIV) == 0;
        m_g = 5'b0;
        served = 0;
        if (!odd) begin
            if (vid_req) m_g = 5'b10000;
            else if (snd_req) m_g = 5'b01000;
            else if (m_pend) begin m_g = 5'b00100; served = 1; end
`ifdef CPU_EVENSHARE_EN
            else if (m_mode == M_CPU && cpu_as) m_g = 5'b00010;
`endif
        end else begin
            if (m_mode == M_CPU && cpu_as) m_g = 5'b00010;
            else if (m_mode == M_DMA && dma_req) m_g = 5'b00001;
        end
        m_ovf = wrap && m_pend && !served;
        m_pend = (m_pend && !served) || wrap;
        if (m_mode == M_CPU) begin
            if (dma_req) m_mode = M_WAIT;
        end else if (m_mode == M_WAIT) begin
            if (!dma_req) m_mode = M_CPU;
            else if (!cpu_as && !m_last_cpu) m_mode = M_DMA;
        end else begin
            if (!dma_req) m_mode = M_CPU;
        end
        m_last_cpu = m_g[1];
    endtask

    task automatic do_reset();
        @(negedge clk);
        resb = 1'b0;
        cycsel = 1'b0;
        repeat (2) @(negedge clk);
        resb = 1'b1;
        model_reset();
    endtask

    // One slot: cycsel high for 'high' clocks, 'len' clocks total; optional cpu_as drop / vid,snd flip.
    task automatic drive_slot(input int len, input int high, input int drop_at, input int flip_at);
        int dcnt;
        bit as_prev;
        bit cpu_e;
        model_start();
        cur_len = len;
        cpu_e = m_g[1];
        dcnt = 0;
        as_prev = 1'b0;
        cycsel = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i > 0 && cpu_e && as_prev && dcnt < 7) dcnt++;
            if (drop_at > 0 && i == drop_at) cpu_as = 1'b0;
            if (flip_at > 0 && i == flip_at) begin vid_req = ~vid_req; snd_req = ~snd_req; end
            #1;
            obs_v[i] = {vid_gnt, snd_gnt, ref_gnt, cpu_gnt, dma_gnt, slot_odd, bus_dma, dtack, ref_ovf};
            exp_v[i] = {m_g, m_n[0], (m_mode == M_DMA), (cpu_e && cpu_as && dcnt >= DLY), ((i == 0) && m_ovf)};
            if (i + 1 == high) cycsel = 1'b0;
            as_prev = cpu_as;
        end
    endtask

    task automatic test_reset();
        logic [8:0] o;
        resb = 1'b0;
        repeat (2) @(negedge clk);
        cycsel = 1'b1;
        @(negedge clk);
        cycsel = 1'b0;
        @(negedge clk);
        o = {vid_gnt, snd_gnt, ref_gnt, cpu_gnt, dma_gnt, slot_odd, bus_dma, dtack, ref_ovf};
        checks++;
        if (o !== 9'b0) begin errors++; $display("FAIL reset_hold: got %b expected %b", o, 9'b0); end
        resb = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        o = {vid_gnt, snd_gnt, ref_gnt, cpu_gnt, dma_gnt, slot_odd, bus_dma, dtack, ref_ovf};
        checks++;
        if (o !== 9'b0) begin errors++; $display("FAIL reset_idle: got %b expected %b", o, 9'b0); end
    endtask

    task automatic test_cpu_slots();
        do_reset();
        cpu_as = 1'b1; vid_req = 1'b0; snd_req = 1'b0; dma_req = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            drive_slot(6, 1, 0, 0);
            for (int i = 0; i < cur_len; i++) begin
                checks++;
                if (obs_v[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL cpu_slots slot %0d clk %0d: got %b expected %b", s, i, obs_v[i], exp_v[i]);
                end
            end
            if (s % 2 == 1) begin
                checks++;
                if (obs_v[0][5] !== 1'b1 || obs_v[DLY-1][1] !== 1'b0 || obs_v[DLY][1] !== 1'b1) begin
                    errors++;
                    $display("FAIL cpu_odd_dtack slot %0d: got gnt/dt %b%b%b expected 101", s,
                             obs_v[0][5], obs_v[DLY-1][1], obs_v[DLY][1]);
                end
            end
`ifndef CPU_EVENSHARE_EN
            if (s % 2 == 0) begin
                checks++;
                if (obs_v[0][5] !== 1'b0) begin
                    errors++;
                    $display("FAIL cpu_even_idle slot %0d: got %b expected 0", s, obs_v[0][5]);
                end
            end
`endif
        end
    endtask

    task automatic test_video_priority();
        do_reset();
        cpu_as = 1'b0; vid_req = 1'b1; snd_req = 1'b1; dma_req = 1'b0;
        for (int s = 1; s <= 9; s++) begin
            drive_slot(4, 2, 0, 0);
            for (int i = 0; i < cur_len; i++) begin
                checks++;
                if (obs_v[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL video_prio slot %0d clk %0d: got %b expected %b", s, i, obs_v[i], exp_v[i]);
                end
            end
            checks++;
            if ((s % 2 == 0 && obs_v[0][8:7] !== 2'b10) || obs_v[0][0] !== (s == 8)) begin
                errors++;
                $display("FAIL video_ovf slot %0d: got vid/snd/ovf %b%b%b expected %b0%b", s,
                         obs_v[0][8], obs_v[0][7], obs_v[0][0], (s % 2 == 0), (s == 8));
            end
        end
    endtask

    task automatic test_refresh();
        do_reset();
        cpu_as = 1'b0; vid_req = 1'b0; snd_req = 1'b0; dma_req = 1'b0;
        for (int s = 1; s <= 12; s++) begin
            drive_slot(4, 1, 0, 0);
            for (int i = 0; i < cur_len; i++) begin
                checks++;
                if (obs_v[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL refresh slot %0d clk %0d: got %b expected %b", s, i, obs_v[i], exp_v[i]);
                end
            end
            checks++;
            if (obs_v[0][6] !== (s == 6 || s == 10)) begin
                errors++;
                $display("FAIL refresh_slot slot %0d: got %b expected %b", s, obs_v[0][6], (s == 6 || s == 10));
            end
        end
    endtask

    task automatic test_dma_handoff();
        do_reset();
        cpu_as = 1'b1; vid_req = 1'b0; snd_req = 1'b0; dma_req = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            if (s == 6) cpu_as = 1'b0;
            if (s == 10) dma_req = 1'b0;
            if (s == 11) begin dma_req = 1'b1; cpu_as = 1'b1; end
            if (s == 12) dma_req = 1'b0;
            drive_slot(5, 1, 0, 0);
            for (int i = 0; i < cur_len; i++) begin
                checks++;
                if (obs_v[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL dma_handoff slot %0d clk %0d: got %b expected %b", s, i, obs_v[i], exp_v[i]);
                end
            end
            checks++;
            if (obs_v[0][2] !== (s >= 6 && s <= 9) || obs_v[0][4] !== (s == 7 || s == 9)) begin
                errors++;
                $display("FAIL dma_bus slot %0d: got bus/dma %b%b expected %b%b", s, obs_v[0][2], obs_v[0][4],
                         (s >= 6 && s <= 9), (s == 7 || s == 9));
            end
        end
    endtask

    task automatic test_dtack_gate();
        do_reset();
        cpu_as = 1'b1; vid_req = 1'b0; snd_req = 1'b0; dma_req = 1'b0;
        drive_slot(8, 1, 5, 3);
        for (int i = 0; i < cur_len; i++) begin
            checks++;
            if (obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL dtack_gate clk %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
        checks++;
        if (obs_v[4][1] !== 1'b1 || obs_v[5][1] !== 1'b0 || obs_v[5][5] !== 1'b1 || obs_v[5][8] !== 1'b0) begin
            errors++;
            $display("FAIL dtack_drop: got dt4/dt5/cpu5/vid5 %b%b%b%b expected 1010",
                     obs_v[4][1], obs_v[5][1], obs_v[5][5], obs_v[5][8]);
        end
        drive_slot(4, 1, 0, 0);
        checks++;
        if (obs_v[0][8] !== 1'b1 || obs_v[0][8] !== exp_v[0][8]) begin
            errors++;
            $display("FAIL late_vid: got %b expected 1", obs_v[0][8]);
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] o;
        do_reset();
        cpu_as = 1'b1; vid_req = 1'b0; snd_req = 1'b0; dma_req = 1'b0;
        drive_slot(5, 1, 0, 0);
        for (int i = 0; i < cur_len; i++) begin
            checks++;
            if (obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL async_pre clk %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
        #2;
        checks++;
        if (dtack !== 1'b1) begin errors++; $display("FAIL async_dtack_on: got %b expected 1", dtack); end
        resb = 1'b0;
        #1;
        o = {vid_gnt, snd_gnt, ref_gnt, cpu_gnt, dma_gnt, slot_odd, bus_dma, dtack, ref_ovf};
        checks++;
        if (o !== 9'b0) begin errors++; $display("FAIL async_clear: got %b expected %b", o, 9'b0); end
        resb = 1'b1;
        model_reset();
        @(negedge clk);
        drive_slot(5, 1, 0, 0);
        for (int i = 0; i < cur_len; i++) begin
            checks++;
            if (obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL async_post clk %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
            end
        end
        checks++;
        if (obs_v[0][3] !== 1'b1 || obs_v[0][5] !== 1'b1 || obs_v[DLY-1][1] !== 1'b0 || obs_v[DLY][1] !== 1'b1) begin
            errors++;
            $display("FAIL async_fresh: got odd/cpu/dt %b%b%b%b expected 1101",
                     obs_v[0][3], obs_v[0][5], obs_v[DLY-1][1], obs_v[DLY][1]);
        end
    endtask

    task automatic test_random();
        int len, high, drop, flip;
        do_reset();
        for (int s = 1; s <= 80; s++) begin
            vid_req = ($urandom % 4) == 0;
            snd_req = ($urandom % 4) == 0;
            cpu_as  = ($urandom % 2) == 0;
            dma_req = ($urandom % 3) == 0;
            len  = $urandom_range(3, 9);
            high = $urandom_range(1, len - 1);
            drop = (($urandom % 4) == 0) ? $urandom_range(1, len - 1) : 0;
            flip = (($urandom % 4) == 0) ? $urandom_range(1, len - 1) : 0;
            drive_slot(len, high, drop, flip);
            for (int i = 0; i < cur_len; i++) begin
                checks++;
                if (obs_v[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL random slot %0d clk %0d: got %b expected %b", s, i, obs_v[i], exp_v[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cpu_slots();
        test_video_priority();
        test_refresh();
        test_dma_handoff();
        test_dtack_gate();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
